// File: rtl/mult_hw_400_pkg.sv
// Shared types and constants for the mult_hw_400 datapath reduction stage.
package mult_hw_400_pkg;

  localparam int unsigned N_ELEM = 400;
  localparam int unsigned PROD_W = 32;
  localparam int unsigned ACC_W  = 41;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned DOUT_W = 32;

  localparam logic [DOUT_W-1:0] SAT_MAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] SAT_MIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_hw_400_acc_reduce_if.sv
// Product-in / result-out handshake bundle for the reduction stage.
interface mult_hw_400_acc_reduce_if
  import mult_hw_400_pkg::*;
#(
  parameter int unsigned IN_W  = PROD_W,
  parameter int unsigned OUT_W = DOUT_W
);
  logic [IN_W-1:0]  din;
  logic             din_vld;
  logic [OUT_W-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;

  modport master (output din, din_vld, dout_rdy, input dout, dout_vld);
  modport slave  (input din, din_vld, dout_rdy, output dout, dout_vld);
endinterface

// File: rtl/mult_hw_400_acc_sat.sv
// Combinational accumulator-to-result converter: wraps by default,
// saturates to the signed result range when MULT_HW_ACC_SAT_EN is defined.
module mult_hw_400_acc_sat
  import mult_hw_400_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = ACC_W,
  parameter int unsigned DOUT_WIDTH = DOUT_W
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DOUT_WIDTH-1:0] res_c
);

`ifdef MULT_HW_ACC_SAT_EN
  // In range iff every bit from the result sign bit upward matches.
  logic [ACC_WIDTH-DOUT_WIDTH:0] hi_bits;
  assign hi_bits = acc[ACC_WIDTH-1:DOUT_WIDTH-1];

  always_comb begin
    res_c = acc[DOUT_WIDTH-1:0];
    if (!((&hi_bits) || !(|hi_bits))) begin
      if (acc[ACC_WIDTH-1]) res_c = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
      else                  res_c = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc[ACC_WIDTH-1:DOUT_WIDTH];
  assign res_c     = acc[DOUT_WIDTH-1:0];
`endif

endmodule

// File: rtl/mult_hw_400_acc_reduce.sv
// Accumulates N signed products into a widened sum and returns it over a
// valid/ready handshake. Result mode selected by MULT_HW_ACC_SAT_EN.
module mult_hw_400_acc_reduce
  import mult_hw_400_pkg::*;
#(
  parameter int unsigned N          = N_ELEM,
  parameter int unsigned din_WIDTH  = PROD_W,
  parameter int unsigned ACC_WIDTH  = ACC_W,
  parameter int unsigned dout_WIDTH = DOUT_W,
  parameter int unsigned CNT_WIDTH  = CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      start,
  mult_hw_400_acc_reduce_if.slave   bus,
  output logic                      busy,
  output logic                      done
);

  state_t                 state, state_d;
  logic [ACC_WIDTH-1:0]   acc, acc_d, acc_sum;
  logic [CNT_WIDTH-1:0]   cnt, cnt_d;
  logic [dout_WIDTH-1:0]  dout_q, dout_d, res_c;
  logic                   vld_q, vld_d;
  logic                   busy_d, done_d;
  logic                   last_beat;

  assign acc_sum   = acc + {{(ACC_WIDTH-din_WIDTH){bus.din[din_WIDTH-1]}}, bus.din};
  assign last_beat = (cnt == CNT_WIDTH'(N - 1));

  mult_hw_400_acc_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DOUT_WIDTH (dout_WIDTH)
  ) u_sat (
    .acc   (acc_sum),
    .res_c (res_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    dout_d  = dout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACCUM: begin
        if (ce && bus.din_vld) begin
          acc_d = acc_sum;
          if (last_beat) begin
            state_d = HOLD;
            cnt_d   = '0;
            dout_d  = res_c;
            vld_d   = 1'b1;
          end else begin
            cnt_d = cnt + CNT_WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (vld_q && bus.dout_rdy) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      busy   <= busy_d;
      done   <= done_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;

  // Upstream must not issue products while a result is waiting.
  a_no_din_in_hold: assert property (@(posedge clk) disable iff (!reset)
    !(state == HOLD && bus.din_vld))
    else $error("din_vld asserted while result held; beat dropped");

endmodule

// File: tb/tb_mult_hw_400_acc_reduce.sv
// Randomized self-checking bench for mult_hw_400_acc_reduce (either MULT_HW_ACC_SAT_EN build).
module tb_mult_hw_400_acc_reduce;

  localparam int N = 400;

  logic clk = 1'b0;
  logic reset, ce, start, busy, done;
  int   n_cmp = 0;
  int   n_err = 0;

  mult_hw_400_acc_reduce_if bus ();

  mult_hw_400_acc_reduce dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .start (start),
    .bus   (bus.slave),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer sum of accepted products, then wrap or clamp.
  function automatic logic [31:0] ref_dout(input longint s);
`ifdef MULT_HW_ACC_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7fff_ffff;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return 32'(s);
  endfunction

  task automatic do_start();
    bus.din_vld = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
  endtask

  // mode: 0 const val, 1 alternating +3/-1, 2 random. stall: 0 none, 1 pattern, 2 random.
  task automatic feed(input int mode, input logic [31:0] val, input int beats,
                      input int stall, output longint sum);
    int k = 0;
    int cyc = 0;
    logic c, v;
    logic [31:0] d;
    sum = 0;
    while (k < beats) begin
      case (stall)
        0:       begin c = 1'b1; v = 1'b1; end
        1:       begin v = (cyc % 2 == 0); c = (cyc % 3 != 2); end
        default: begin c = ($urandom_range(0, 3) != 0); v = ($urandom_range(0, 3) != 0); end
      endcase
      case (mode)
        0:       d = val;
        1:       d = (k % 2 == 0) ? 32'd3 : 32'hffff_ffff;
        default: d = $urandom;
      endcase
      ce = c;
      bus.din_vld = v;
      bus.din = d;
      start = (mode == 2 && k == beats / 2);
      if (c && v) begin
        sum += longint'($signed(d));
        k++;
      end
      tick();
      cyc++;
      if (k < N) chk("early_vld", bus.dout_vld, 0);
      if (k == beats / 2 && c && v) chk("mid_busy", busy, 1);
      if (cyc > 20000) begin
        chk("feed_timeout", 1, 0);
        break;
      end
    end
    ce = 1'b1;
    bus.din_vld = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input longint sum);
    chk({tag, "_vld"}, bus.dout_vld, 1);
    chk({tag, "_dout"}, bus.dout, ref_dout(sum));
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_done"}, done, 0);
  endtask

  // Holds dout_rdy low, pulses start, then completes the handshake with start high.
  task automatic drain(input int hold_cycles, input logic [31:0] exp, input bit b2b);
    bus.dout_rdy = 1'b0;
    for (int i = 0; i < hold_cycles; i++) begin
      start = (i % 2 == 0);
      tick();
      chk("hold_vld", bus.dout_vld, 1);
      chk("hold_dout", bus.dout, exp);
      chk("hold_busy", busy, 1);
      chk("hold_done", done, 0);
    end
    start = 1'b1;
    bus.dout_rdy = 1'b1;
    tick();
    start = 1'b0;
    bus.dout_rdy = 1'b0;
    chk("hs_vld", bus.dout_vld, 0);
    chk("hs_done", done, 1);
    chk("hs_busy", busy, 0);
    if (!b2b) begin
      tick();
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
    end
  endtask

  initial begin
    longint s;
    reset = 1'b0;
    ce = 1'b0;
    start = 1'b0;
    bus.din = '0;
    bus.din_vld = 1'b0;
    bus.dout_rdy = 1'b0;
    repeat (2) tick();
    chk("rst_dout", bus.dout, 0);
    chk("rst_vld", bus.dout_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b1;

    // din_vld while idle must not start anything.
    ce = 1'b1;
    bus.din_vld = 1'b1;
    bus.din = 32'h1234_5678;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_vld", bus.dout_vld, 0);

    do_start();
    feed(0, 32'd1, N, 0, s);
    check_result("ones", s);
    chk("ones_lit", bus.dout, 32'd400);
    drain(0, ref_dout(s), 1'b0);

    do_start();
    feed(0, 32'hffff_ffff, N, 1, s);
    check_result("neg", s);
    chk("neg_lit", bus.dout, 32'hffff_fe70);
    drain(10, ref_dout(s), 1'b0);

    do_start();
    feed(0, 32'h7fff_ffff, N, 0, s);
    check_result("maxpos", s);
    drain(0, ref_dout(s), 1'b0);

    do_start();
    feed(0, 32'h8000_0000, N, 2, s);
    check_result("maxneg", s);
    drain(2, ref_dout(s), 1'b0);

    // Reset mid-reduction discards the partial sum.
    do_start();
    feed(0, 32'd5, 200, 0, s);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_vld", bus.dout_vld, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_dout", bus.dout, 0);
    do_start();
    feed(0, 32'd2, N, 0, s);
    check_result("after_rst", s);
    chk("after_rst_lit", bus.dout, 32'd800);
    drain(1, ref_dout(s), 1'b1);

    // Back-to-back start right after done.
    do_start();
    feed(1, 32'd0, N, 0, s);
    check_result("alt", s);
    chk("alt_lit", bus.dout, 32'd400);
    drain(0, ref_dout(s), 1'b0);

    for (int r = 0; r < 3; r++) begin
      do_start();
      feed(2, 32'd0, N, 2, s);
      check_result("rand", s);
      drain($urandom_range(0, 4), ref_dout(s), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_hw_400_acc_reduce.md
Name: mult_hw_400_acc_reduce

Overview:
Downstream consumer of the 32x32 signed pipelined multiplier in the mult_hw_400 datapath.
- Accepts one signed 32-bit product per cycle and accumulates exactly N products into a widened accumulator.
- Presents the final sum through a valid/ready output handshake.
- Turns the element-wise multiply stream into a dot-product / reduction result for the 400-element vector kernel.

Parameters:
N, 400, number of products per reduction (>=1)
din_WIDTH, 32, product input width (signed)
ACC_WIDTH, 41, internal accumulator width; must be >= din_WIDTH + ceil(log2(N))
dout_WIDTH, 32, result width (signed)
CNT_WIDTH, 9, element counter width; must be >= ceil(log2(N))

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
ce  in  1  clock enable for the accumulate path, same signal that drives the multiplier ce
start  in  1  single-cycle pulse: begin a new reduction
din  in  din_WIDTH  signed product from multiplier dout
din_vld  in  1  din valid; upstream control delays its issue-valid by the multiplier latency (1 ce-qualified cycle)
dout  out  dout_WIDTH  reduction result
dout_vld  out  1  result valid
dout_rdy  in  1  consumer ready
busy  out  1  high in ACCUM and HOLD
done  out  1  one-cycle pulse on result handshake

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE; acc=0, cnt=0.
  - Outputs: dout=0, dout_vld=0, busy=0, done=0.
  - Reset overrides everything, including mid-ACCUM and mid-HOLD; partial sums are discarded.
- FSM, one encoded state register:
  - IDLE:
    - start=1 -> ACCUM; acc<=0, cnt<=0.
    - din_vld in IDLE is ignored.
  - ACCUM:
    - On ce && din_vld: acc<=acc+sext(din), cnt<=cnt+1.
    - When the accepted beat is number N (cnt==N-1 before increment): go to HOLD, register dout from the final sum, dout_vld<=1.
    - With ce=0 or din_vld=0, acc, cnt and state hold.
    - start is ignored while in ACCUM.
  - HOLD:
    - dout and dout_vld are stable until dout_rdy=1.
    - On dout_vld && dout_rdy: dout_vld<=0, done<=1 for one cycle, state -> IDLE.
    - Any din_vld in HOLD is dropped; this is an upstream protocol error and is flagged in simulation with an assertion.
    - The handshake is independent of ce.
    - start is ignored in HOLD.
- start in the same cycle as the completing handshake: ignored. A new start is accepted from IDLE the following cycle or later.
- Latency: dout_vld rises 1 clk after the N-th accepted beat. Minimum reduction time is N+1 cycles plus the handshake.
- Arithmetic:
  - Two's complement throughout; the accumulator never overflows for ACC_WIDTH at or above the stated bound.
  - Default dout = acc[dout_WIDTH-1:0], i.e. wrap semantics identical to C int accumulation in the HLS source.
- Counter: cnt never exceeds N-1. With N=1 the first accepted beat goes directly to HOLD.
- done is 0 in every cycle other than the one after the output handshake.

Optional Feature:
MULT_HW_ACC_SAT_EN
- Defined: dout is acc saturated to the signed dout_WIDTH range:
  - acc > 2^(dout_WIDTH-1)-1 -> 0x7FFFFFFF
  - acc < -2^(dout_WIDTH-1) -> 0x80000000
  - otherwise acc truncated.
  - Saturation is computed combinationally on the final sum before the dout register, so latency is unchanged.
- Undefined: wrap/truncate as above.

Decomposition:
- Shared package mult_hw_400_pkg:
  - FSM state typedef (IDLE, ACCUM, HOLD).
  - Constants N_ELEM=400, PROD_W=32, ACC_W=41, CNT_W=9.
  - Saturation min/max constants.
- One natural sub-module, mult_hw_400_acc_sat: combinational ACC_WIDTH->dout_WIDTH wrap-or-saturate converter, selected by the macro.
- The FSM, counter and accumulator stay in the top module.

Test Plan:
- Reset, start, 400 beats din=1 (ce=1, din_vld=1 every cycle), dout_rdy=1 -> dout_vld 1 cycle after beat 400, dout=400, done pulses once, busy falls.
- 400 beats din=-1 with din_vld toggling 1/0 and ce low every 3rd cycle -> dout=-400 (0xFFFFFE70); cnt/acc frozen on stalled cycles.
- 400 beats din=0x7FFFFFFF -> without macro dout=0xFFFFFE70 (wrap); with MULT_HW_ACC_SAT_EN dout=0x7FFFFFFF. Repeat with din=0x80000000 -> wrap 0x00000000 / sat 0x80000000.
- Hold dout_rdy=0 for 10 cycles after completion while pulsing start and din_vld -> dout and dout_vld stable, start ignored, assertion fires on din_vld. dout_rdy=1 -> done pulse, IDLE.
- reset=0 at beat 200, then start plus 400 beats of din=2 -> dout=800; the pre-reset partial sum has no effect.
- Back-to-back: start the cycle after done, alternating din=+3/-1 for 400 beats -> dout=400.
